// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double dabble, one bit per clock).
// Define BIN2BCD_SATURATE_EN to clamp overflowing results to 16'h9999; otherwise the low four digits are kept.
//
// state | meaning
// IDLE  | waiting for i_Start; o_Bcd/o_Ovf hold the last result
// SHIFT | 16 add-3/shift iterations over the scratch register
// DONE  | publish result, pulse o_Done, return to IDLE
module bin2bcd_seq (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic [15:0] i_Bin,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [15:0] o_Bcd,
  output logic        o_Ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [35:0] scratch;
  logic [35:0] adjusted;
  logic [3:0]  count;
  logic        ovf_next;
  logic [15:0] bcd_next;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_Start) state_next = SHIFT;
      SHIFT:   if (count == 4'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_Busy = (state != IDLE);
  end

  // Upper 20 bits hold five BCD digits (ten-thousands included), lower 16 the remaining binary.
  always_comb begin
    adjusted = scratch;
    for (int d = 0; d < 5; d++) begin
      if (scratch[16+4*d +: 4] >= 4'd5)
        adjusted[16+4*d +: 4] = scratch[16+4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    ovf_next = (scratch[35:32] != 4'd0);
`ifdef BIN2BCD_SATURATE_EN
    bcd_next = ovf_next ? 16'h9999 : scratch[31:16];
`else
    bcd_next = scratch[31:16];
`endif
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      scratch <= '0;
      count   <= '0;
      o_Bcd   <= '0;
      o_Ovf   <= 1'b0;
      o_Done  <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start) begin
            scratch <= {20'd0, i_Bin};
            count   <= '0;
          end
        end
        SHIFT: begin
          scratch <= {adjusted[34:0], 1'b0};
          count   <= count + 4'd1;
        end
        DONE: begin
          o_Bcd  <= bcd_next;
          o_Ovf  <= ovf_next;
          o_Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected results are queued at each accepting edge
// and checked by an independent monitor whenever o_Done pulses.
module tb_bin2bcd_seq;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_Start = 1'b0;
  logic [15:0] i_Bin = '0;
  logic        o_Busy, o_Done, o_Ovf;
  logic [15:0] o_Bcd;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pushes = 0;
  int dones = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
    int          bin;
  } exp_t;
  exp_t sb[$];

  bin2bcd_seq dut (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Start(i_Start),
    .i_Bin  (i_Bin),
    .o_Busy (o_Busy),
    .o_Done (o_Done),
    .o_Bcd  (o_Bcd),
    .o_Ovf  (o_Ovf)
  );

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int v);
    int m;
    m = v % 10000;
`ifdef BIN2BCD_SATURATE_EN
    if (v > 9999) return 16'h9999;
`endif
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic push(input int v);
    exp_t e;
    e.bcd = ref_bcd(v);
    e.ovf = (v > 9999);
    e.cyc = cyc;
    e.bin = v;
    sb.push_back(e);
    pushes++;
  endtask

  // Monitor: compare at negedge whenever a result is presented.
  always @(negedge i_Clk) begin
    if (o_Done) begin
      exp_t e;
      dones++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got o_Done=1 expected no pending conversion (bcd=%0h)", o_Bcd);
      end else begin
        e = sb.pop_front();
        check($sformatf("bcd(%0d)", e.bin), 32'(o_Bcd), 32'(e.bcd));
        check($sformatf("ovf(%0d)", e.bin), 32'(o_Ovf), 32'(e.ovf));
        check($sformatf("latency(%0d)", e.bin), 32'(cyc - e.cyc), 32'd17);
        check("busy_at_done", 32'(o_Busy), 32'd0);
      end
    end
  end

  // Caller is positioned #1 after an edge.
  task automatic wait_idle();
    int n = 0;
    while (o_Busy && n < 50) begin
      @(posedge i_Clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic convert(input int v);
    wait_idle();
    i_Start = 1'b1;
    i_Bin   = 16'(v);
    @(posedge i_Clk); #1;
    push(v);
    i_Start = 1'b0;
    i_Bin   = 16'($urandom);
    check("busy_after_accept", 32'(o_Busy), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge i_Clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_done", 32'(o_Done), 32'd0);
    check("rst_bcd",  32'(o_Bcd),  32'd0);
    check("rst_ovf",  32'(o_Ovf),  32'd0);
    @(posedge i_Clk); #1;
    i_Rst = 1'b0;
    @(posedge i_Clk); #1;

    // Zero operand with busy profile E1..E16.
    convert(0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge i_Clk); #1;
      check($sformatf("busy_E%0d", k), 32'(o_Busy), 32'd1);
    end
    drain();

    // Start held high: 1234 then 9999, accepted 18 cycles apart.
    wait_idle();
    i_Start = 1'b1;
    i_Bin   = 16'd1234;
    @(posedge i_Clk); #1;
    push(1234);
    i_Bin = 16'd9999;
    repeat (18) @(posedge i_Clk);
    #1;
    push(9999);
    i_Start = 1'b0;
    i_Bin   = 16'd3;
    drain();

    convert(10000);
    convert(65535);
    drain();

    // Start pulse during SHIFT is ignored.
    convert(42);
    repeat (4) @(posedge i_Clk);
    #1;
    i_Start = 1'b1;
    i_Bin   = 16'd77;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    drain();
    repeat (3) @(posedge i_Clk);
    #1;

    // Reset mid-conversion aborts without a done pulse.
    convert(500);
    drain();
    wait_idle();
    i_Start = 1'b1;
    i_Bin   = 16'd321;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    repeat (8) @(posedge i_Clk);
    #1;
    i_Rst = 1'b1;
    #1;
    check("abort_bcd",  32'(o_Bcd),  32'd0);
    check("abort_ovf",  32'(o_Ovf),  32'd0);
    check("abort_busy", 32'(o_Busy), 32'd0);
    check("abort_done", 32'(o_Done), 32'd0);
    repeat (3) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    repeat (20) @(posedge i_Clk);
    #1;
    check("idle_after_abort", 32'(o_Busy), 32'd0);
    convert(7);
    drain();

    for (int k = 0; k < 12; k++) convert(int'($urandom_range(0, 65535)));
    for (int k = 0; k < 6; k++)  convert(int'($urandom_range(9990, 10010)));
    drain();

    repeat (20) @(posedge i_Clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("done_count", 32'(dones), 32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
